// File: rtl/norm_unit.sv
// Iterative 16-bit normalizer: counts leading zeros (sgn=0) or redundant leading
// sign bits (sgn=1) with a 4-stage 8/4/2/1 shift search, then reports the result.
module norm_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sgn,
    input  logic [15:0] src0,
    output logic        busy,
    output logic        done,
    output logic [15:0] opt,
    output logic [3:0]  shamt,
    output logic        zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  k;
    logic [15:0] w;
    logic [15:0] w_nxt;
    logic [3:0]  c;
    logic [3:0]  c_nxt;
    logic [3:0]  step;
    logic        sg;
    logic        z;
    logic        hit;

    // Stage k examines the top n bits (zero mode) or n+1 bits (sign mode), n = 8>>k.
    always_comb begin
        hit = 1'b0;
        case (k)
            2'd0:    hit = sg ? ((&w[15:7])  | ~(|w[15:7]))  : ~(|w[15:8]);
            2'd1:    hit = sg ? ((&w[15:11]) | ~(|w[15:11])) : ~(|w[15:12]);
            2'd2:    hit = sg ? ((&w[15:13]) | ~(|w[15:13])) : ~(|w[15:14]);
            default: hit = sg ? (w[15] == w[14])             : ~w[15];
        endcase
    end

    assign step  = 4'b1000 >> k;
    assign w_nxt = hit ? (w << step) : w;
    assign c_nxt = hit ? (c + step) : c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (k == 2'd3) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT) || (state == DONE);
        done = (state == DONE);
    end

    // The zero flag is decided from the operand at load time, not from the shifted value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k     <= 2'd0;
            w     <= 16'h0000;
            c     <= 4'd0;
            sg    <= 1'b0;
            z     <= 1'b0;
            opt   <= 16'h0000;
            shamt <= 4'd0;
            zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        w  <= src0;
                        c  <= 4'd0;
                        sg <= sgn;
                        z  <= sgn ? ((src0 == 16'h0000) || (src0 == 16'hFFFF))
                                  : (src0 == 16'h0000);
                        k  <= 2'd0;
                    end
                end
                SHIFT: begin
                    w <= w_nxt;
                    c <= c_nxt;
                    k <= k + 2'd1;
                    if (k == 2'd3) begin
                        opt   <= w_nxt;
                        shamt <= c_nxt;
                        zero  <= z;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_norm_unit.sv
// Self-checking bench for norm_unit: directed vector table, multi-cycle corner
// sequences (back-to-back start, mid-operation reset) and a random model sweep.
module tb_norm_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [15:0] src0;
    logic        busy;
    logic        done;
    logic [15:0] opt;
    logic [3:0]  shamt;
    logic        zero;

    int checks = 0;
    int errors = 0;

    logic [20:0] exp_q[$];

    typedef struct {
        logic [15:0] src;
        logic        sg;
        logic [15:0] opt;
        logic [3:0]  sh;
        logic        z;
    } vec_t;

    vec_t vecs[12];

    norm_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sgn   (sgn),
        .src0  (src0),
        .busy  (busy),
        .done  (done),
        .opt   (opt),
        .shamt (shamt),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: {zero, shamt, opt} computed by scanning bits from the top.
    function automatic logic [20:0] ref_norm(input logic [15:0] s, input logic g);
        int          cnt;
        logic        zz;
        logic [15:0] o;
        cnt = 0;
        if (!g) begin
            for (int i = 15; i >= 0; i--) begin
                if (s[i] != 1'b0) break;
                cnt++;
            end
        end else begin
            for (int i = 14; i >= 0; i--) begin
                if (s[i] != s[15]) break;
                cnt++;
            end
        end
        if (cnt > 15) cnt = 15;
        zz = g ? ((s == 16'h0000) || (s == 16'hFFFF)) : (s == 16'h0000);
        o  = s << cnt;
        return {zz, cnt[3:0], o};
    endfunction

    // Drives one request, scrambles the inputs after the sampling edge,
    // then waits (bounded) for done.
    task automatic run_op(input logic [15:0] s, input logic g,
                          output logic [15:0] o, output logic [3:0] sh, output logic z,
                          output int lat, output int busy_n);
        @(negedge clk);
        start = 1'b1;
        src0  = s;
        sgn   = g;
        @(posedge clk);
        #1;
        start = 1'b0;
        src0  = 16'($urandom_range(0, 65535));
        sgn   = 1'($urandom_range(0, 1));
        lat    = 0;
        busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (busy) busy_n++;
            if (done) break;
        end
        o  = opt;
        sh = shamt;
        z  = zero;
    endtask

    initial begin
        logic [15:0] o;
        logic [3:0]  sh;
        logic        z;
        int          lat;
        int          busy_n;
        logic [20:0] e;
        logic [15:0] rs;
        logic        rg;
        logic [15:0] sv;
        logic [15:0] vals[30];
        bit          saw_done;

        vecs[0]  = '{16'h0001, 1'b0, 16'h8000, 4'd15, 1'b0};
        vecs[1]  = '{16'h00F0, 1'b0, 16'hF000, 4'd8,  1'b0};
        vecs[2]  = '{16'hFFF3, 1'b1, 16'h9800, 4'd11, 1'b0};
        vecs[3]  = '{16'h0000, 1'b1, 16'h0000, 4'd15, 1'b1};
        vecs[4]  = '{16'h0000, 1'b0, 16'h0000, 4'd15, 1'b1};
        vecs[5]  = '{16'hFFFF, 1'b1, 16'h8000, 4'd15, 1'b1};
        vecs[6]  = '{16'hFFFF, 1'b0, 16'hFFFF, 4'd0,  1'b0};
        vecs[7]  = '{16'h8000, 1'b0, 16'h8000, 4'd0,  1'b0};
        vecs[8]  = '{16'h4000, 1'b1, 16'h4000, 4'd0,  1'b0};
        vecs[9]  = '{16'h0001, 1'b1, 16'h4000, 4'd14, 1'b0};
        vecs[10] = '{16'h7FFF, 1'b1, 16'h7FFF, 4'd0,  1'b0};
        vecs[11] = '{16'h1234, 1'b0, 16'h91A0, 4'd3,  1'b0};

        // Reset values while rst is held
        rst   = 1'b1;
        start = 1'b0;
        sgn   = 1'b0;
        src0  = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset_opt",   32'(opt),   32'h0);
        check("reset_shamt", 32'(shamt), 32'h0);
        check("reset_zero",  32'(zero),  32'h0);
        check("reset_busy",  32'(busy),  32'h0);
        check("reset_done",  32'(done),  32'h0);
        rst = 1'b0;

        // Directed vector table
        foreach (vecs[i]) begin
            run_op(vecs[i].src, vecs[i].sg, o, sh, z, lat, busy_n);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
            check($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 32'd5);
            check($sformatf("vec%0d_opt", i), 32'(o), 32'(vecs[i].opt));
            check($sformatf("vec%0d_shamt", i), 32'(sh), 32'(vecs[i].sh));
            check($sformatf("vec%0d_zero", i), 32'(z), 32'(vecs[i].z));
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
            check($sformatf("vec%0d_idle_busy", i), 32'(busy), 32'd0);
            check($sformatf("vec%0d_opt_hold", i), 32'(opt), 32'(vecs[i].opt));
        end

        // Start held high, src0 changing every cycle: samples at cycles 0,6,12,18
        for (int c = 0; c < 30; c++) vals[c] = 16'($urandom_range(1, 65535));
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            check($sformatf("b2b_done_c%0d", c), 32'(done),
                  32'((c >= 5) && (c <= 23) && ((c - 5) % 6 == 0)));
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("b2b_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("b2b_opt_c%0d", c), 32'(opt), 32'(e[15:0]));
                    check($sformatf("b2b_shamt_c%0d", c), 32'(shamt), 32'(e[19:16]));
                end
            end
            start = (c <= 18);
            sgn   = 1'b0;
            src0  = vals[c];
            if ((c % 6 == 0) && (c <= 18)) exp_q.push_back(ref_norm(vals[c], 1'b0));
        end
        start = 1'b0;
        check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset during stage k=2
        @(negedge clk);
        start = 1'b1;
        src0  = 16'h1234;
        sgn   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy",  32'(busy),  32'd0);
        check("midrst_done",  32'(done),  32'd0);
        check("midrst_opt",   32'(opt),   32'h0);
        check("midrst_shamt", 32'(shamt), 32'h0);
        check("midrst_zero",  32'(zero),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("midrst_no_done", 32'(saw_done), 32'd0);
        run_op(16'h4000, 1'b0, o, sh, z, lat, busy_n);
        check("postrst_latency", 32'(lat), 32'd5);
        check("postrst_opt",   32'(o),  32'h8000);
        check("postrst_shamt", 32'(sh), 32'd1);
        check("postrst_zero",  32'(z),  32'd0);

        // Start on the first edge after reset release
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        src0  = 16'h0003;
        sgn   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("rst_release_accept", 32'(busy), 32'd1);
        repeat (5) @(negedge clk);

        // Random sweep against the bit-scan model plus shift-back consistency
        for (int n = 0; n < 10000; n++) begin
            rs = 16'($urandom_range(0, 65535));
            rg = 1'($urandom_range(0, 1));
            if (n % 50 == 0) rs = rg ? 16'hFFFF : 16'h0000;
            e = ref_norm(rs, rg);
            run_op(rs, rg, o, sh, z, lat, busy_n);
            check("rand_opt",   32'(o),  32'(e[15:0]));
            check("rand_shamt", 32'(sh), 32'(e[19:16]));
            check("rand_zero",  32'(z),  32'(e[20]));
            if (rs != 16'h0000) begin
                sv = rg ? 16'($signed(o) >>> sh) : (o >> sh);
                check("rand_shift_back", 32'(sv), 32'(rs));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
